// File: rtl/prng_chip_sched.sv
// ---------------------------------------------------------------------------
// prng_chip_sched
//
// Chip-rate scheduler for the PRN generator of the GPS signal generator.
// Divides clk_in down to a programmable chip rate and emits one enable pulse
// per chip toward the generator. Counts chips modulo CODE_LEN and flags code
// epochs. Runs an IDLE/RUN/PAUSE sequence driven by level requests.
//
// The generator shares clk_in/rst_in_n with this block, so both leave reset
// aligned at chip 0. chip_cnt_out is the index of the chip the generator
// presents at the next enable pulse.
//
// Optional feature macro: PRNG_SYNC_CHECK_EN
//   defined   : prng_start_in is compared against the local chip index on
//               every enable cycle; a mismatch sets the sticky sync_err_out.
//   undefined : no check logic; sync_err_out is tied to 0.
//
// Parameters
//   DIV_BITS  width of chip-period divider input
//   CNT_BITS  width of chip counter (2**CNT_BITS >= CODE_LEN)
//   CODE_LEN  chips per code epoch
//
// Ports
//   clk_in         in   1         single clock
//   rst_in_n       in   1         asynchronous active-low reset
//   start_in       in   1         level, IDLE->RUN request
//   stop_in        in   1         level, RUN/PAUSE->IDLE request (highest priority)
//   hold_in        in   1         level, RUN<->PAUSE
//   div_in         in   DIV_BITS  chip period minus 1 in clocks, sampled on start
//   prng_start_in  in   1         generator start_out (sync check only)
//   prng_ena_out   out  1         one-cycle enable pulse per chip
//   epoch_out      out  1         enable pulse that presents chip 0
//   chip_cnt_out   out  CNT_BITS  chip index presented at the next enable pulse
//   busy_out       out  1         state is not IDLE
//   sync_err_out   out  1         sticky generator/scheduler misalignment flag
// ---------------------------------------------------------------------------
module prng_chip_sched #(
    parameter int DIV_BITS = 8,
    parameter int CNT_BITS = 10,
    parameter int CODE_LEN = 1023
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                start_in,
    input  logic                stop_in,
    input  logic                hold_in,
    input  logic [DIV_BITS-1:0] div_in,
    input  logic                prng_start_in,
    output logic                prng_ena_out,
    output logic                epoch_out,
    output logic [CNT_BITS-1:0] chip_cnt_out,
    output logic                busy_out,
    output logic                sync_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] CHIP_LAST = CNT_BITS'(CODE_LEN - 1);

    state_t              state_q;
    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] div_cnt_q;
    logic [CNT_BITS-1:0] chip_cnt_q;
    logic                ena_q;
    logic                busy_q;
    logic                start_accept;

    // Chip index successor with wrap at the end of the code epoch.
    function automatic logic [CNT_BITS-1:0] chip_next(input logic [CNT_BITS-1:0] c);
        return (c == CHIP_LAST) ? '0 : c + CNT_BITS'(1);
    endfunction

    // Only a start seen in IDLE without a concurrent stop is accepted.
    assign start_accept = (state_q == ST_IDLE) && start_in && !stop_in;

    // Control FSM and chip-rate divider. The divider advances only on edges
    // where the FSM stays in RUN, so the edge that leaves RUN neither counts
    // nor produces a pulse; div_cnt therefore resumes exactly where it froze.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            div_cnt_q <= '0;
            ena_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ena_q     <= 1'b0;
                    div_cnt_q <= '0;
                    if (start_accept) begin
                        state_q <= ST_RUN;
                        div_q   <= div_in;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop_in) begin
                        state_q   <= ST_IDLE;
                        ena_q     <= 1'b0;
                        div_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (hold_in) begin
                        state_q   <= ST_PAUSE;
                        ena_q     <= 1'b0;
                    end else if (div_cnt_q == div_q) begin
                        div_cnt_q <= '0;
                        ena_q     <= 1'b1;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_BITS'(1);
                        ena_q     <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    ena_q <= 1'b0;
                    if (stop_in) begin
                        state_q   <= ST_IDLE;
                        div_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (!hold_in) begin
                        state_q   <= ST_RUN;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    div_cnt_q <= '0;
                    ena_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Chip counter follows the generator: it advances on every edge at which
    // the generator is enabled, independent of the FSM state, and is kept
    // across stop so a restart resumes at the same chip.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            chip_cnt_q <= '0;
        end else if (ena_q) begin
            chip_cnt_q <= chip_next(chip_cnt_q);
        end
    end

`ifdef PRNG_SYNC_CHECK_EN
    logic sync_err_q;
    logic chip_zero;

    assign chip_zero = (chip_cnt_q == '0);

    // The generator must report its start chip exactly when we present chip 0.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync_err_q <= 1'b0;
        end else if (ena_q && (prng_start_in != chip_zero)) begin
            sync_err_q <= 1'b1;
        end else if (start_accept) begin
            sync_err_q <= 1'b0;
        end
    end

    assign sync_err_out = sync_err_q;
`else
    logic unused_prng_start;

    assign unused_prng_start = prng_start_in;
    assign sync_err_out      = 1'b0;
`endif

    assign prng_ena_out = ena_q;
    assign epoch_out    = ena_q && (chip_cnt_q == '0);
    assign chip_cnt_out = chip_cnt_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_prng_chip_sched.sv
module tb_prng_chip_sched;

    localparam int DIV_BITS = 8;
    localparam int CNT_BITS = 3;
    localparam int CODE_LEN = 7;

`ifdef PRNG_SYNC_CHECK_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic                clk_in;
    logic                rst_in_n;
    logic                start_in;
    logic                stop_in;
    logic                hold_in;
    logic [DIV_BITS-1:0] div_in;
    logic                prng_start_in;
    logic                prng_ena_out;
    logic                epoch_out;
    logic [CNT_BITS-1:0] chip_cnt_out;
    logic                busy_out;
    logic                sync_err_out;

    int checks = 0;
    int errors = 0;

    prng_chip_sched #(
        .DIV_BITS(DIV_BITS),
        .CNT_BITS(CNT_BITS),
        .CODE_LEN(CODE_LEN)
    ) dut (
        .clk_in       (clk_in),
        .rst_in_n     (rst_in_n),
        .start_in     (start_in),
        .stop_in      (stop_in),
        .hold_in      (hold_in),
        .div_in       (div_in),
        .prng_start_in(prng_start_in),
        .prng_ena_out (prng_ena_out),
        .epoch_out    (epoch_out),
        .chip_cnt_out (chip_cnt_out),
        .busy_out     (busy_out),
        .sync_err_out (sync_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural PRN generator position: start_out is high while it presents chip 0.
    logic [2:0] gen_chip;
    logic       force_bad;

    always @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n)
            gen_chip <= 3'd0;
        else if (prng_ena_out)
            gen_chip <= (gen_chip == 3'd6) ? 3'd0 : gen_chip + 3'd1;
    end

    assign prng_start_in = force_bad | (gen_chip == 3'd0);

    typedef struct {
        logic       start;
        logic       stop;
        logic       hold;
        logic [7:0] div;
        logic       ena;
        logic       epoch;
        logic [2:0] chip;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic p, input logic h, input logic [7:0] d,
                                input logic e, input logic ep, input logic [2:0] c, input logic b);
        vec_t v;
        v.start = s; v.stop = p; v.hold = h; v.div = d;
        v.ena = e; v.epoch = ep; v.chip = c; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e, input logic ep,
                              input logic [2:0] c, input logic b, input logic se);
        chk({tag, ".ena"},   32'(prng_ena_out), 32'(e));
        chk({tag, ".epoch"}, 32'(epoch_out),    32'(ep));
        chk({tag, ".chip"},  32'(chip_cnt_out), 32'(c));
        chk({tag, ".busy"},  32'(busy_out),     32'(b));
        chk({tag, ".serr"},  32'(sync_err_out), 32'(se));
    endtask

    // Drive inputs just after an edge, then advance one edge and settle.
    task automatic step(input logic s, input logic p, input logic h, input logic [7:0] d);
        start_in = s; stop_in = p; hold_in = h; div_in = d;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in_n  = 1'b0;
        start_in  = 1'b0;
        stop_in   = 1'b0;
        hold_in   = 1'b0;
        div_in    = 8'd3;
        force_bad = 1'b0;

        // start, stop, hold, div | ena, epoch, chip, busy
        vecs.push_back(mk(1,0,0,3, 0,0,0,1));
        vecs.push_back(mk(0,0,0,3, 0,0,0,1));
        vecs.push_back(mk(0,0,0,3, 0,0,0,1));
        vecs.push_back(mk(0,0,0,3, 0,0,0,1));
        vecs.push_back(mk(0,0,0,3, 1,1,0,1));
        vecs.push_back(mk(0,0,0,3, 0,0,1,1));
        vecs.push_back(mk(0,0,0,3, 0,0,1,1));
        vecs.push_back(mk(0,0,0,3, 0,0,1,1));
        vecs.push_back(mk(0,0,0,3, 1,0,1,1));
        vecs.push_back(mk(0,0,0,3, 0,0,2,1));
        vecs.push_back(mk(0,0,0,3, 0,0,2,1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,1,3, 0,0,2,1));
        vecs.push_back(mk(0,0,0,3, 0,0,2,1));
        vecs.push_back(mk(0,0,0,3, 0,0,2,1));
        vecs.push_back(mk(0,0,0,3, 1,0,2,1));
        vecs.push_back(mk(0,0,0,3, 0,0,3,1));
        vecs.push_back(mk(1,1,0,3, 0,0,3,0));
        vecs.push_back(mk(1,1,0,3, 0,0,3,0));
        vecs.push_back(mk(1,0,0,1, 0,0,3,1));
        vecs.push_back(mk(0,0,0,5, 0,0,3,1));
        vecs.push_back(mk(0,0,0,5, 1,0,3,1));
        vecs.push_back(mk(0,0,0,5, 0,0,4,1));
        vecs.push_back(mk(0,0,0,5, 1,0,4,1));
        vecs.push_back(mk(0,0,0,5, 0,0,5,1));
        vecs.push_back(mk(0,0,0,5, 1,0,5,1));
        vecs.push_back(mk(0,0,0,5, 0,0,6,1));
        vecs.push_back(mk(0,0,0,5, 1,0,6,1));
        vecs.push_back(mk(0,0,0,5, 0,0,0,1));
        vecs.push_back(mk(0,0,0,5, 1,1,0,1));
        vecs.push_back(mk(0,1,0,5, 0,0,1,0));

        // Outputs held at zero while in reset and for 10 cycles after release.
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_outs("in_reset", 0, 0, 3'd0, 0, 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 8'd3);
            check_outs($sformatf("post_reset[%0d]", i), 0, 0, 3'd0, 0, 0);
        end

        // Chip rate, hold, stop-over-start, restart with new divider.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].hold, vecs[i].div);
            check_outs($sformatf("vec[%0d]", i), vecs[i].ena, vecs[i].epoch,
                       vecs[i].chip, vecs[i].busy, 0);
        end

        // Run from chip 1 with div 0, then async reset between edges.
        step(1, 0, 0, 8'd0);
        check_outs("ar_start", 0, 0, 3'd1, 1, 0);
        step(0, 0, 0, 8'd0);
        check_outs("ar_run0", 1, 0, 3'd1, 1, 0);
        step(0, 0, 0, 8'd0);
        check_outs("ar_run1", 1, 0, 3'd2, 1, 0);
        #3;
        rst_in_n = 1'b0;
        #1;
        check_outs("ar_async", 0, 0, 3'd0, 0, 0);
        @(posedge clk_in);
        #1;
        check_outs("ar_held", 0, 0, 3'd0, 0, 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;

        // Epoch wrap at div 0, with a forced generator start at chip 5.
        step(1, 0, 0, 8'd0);
        check_outs("wrap_start", 0, 0, 3'd0, 1, 0);
        for (int k = 0; k < 14; k++) begin
            force_bad = (k == 6);
            step(0, 0, 0, 8'd0);
            check_outs($sformatf("wrap[%0d]", k), 1, (k % 7) == 0, 3'(k % 7), 1,
                       SYNC_EN && (k >= 6));
        end
        force_bad = 1'b0;
        step(0, 1, 0, 8'd0);
        check_outs("serr_stop", 0, 0, 3'd0, 0, SYNC_EN);
        step(1, 0, 0, 8'd0);
        check_outs("serr_clear", 0, 0, 3'd0, 1, 0);
        step(0, 0, 0, 8'd0);
        check_outs("serr_run", 1, 1, 3'd0, 1, 0);
        step(0, 1, 0, 8'd0);
        check_outs("final_stop", 0, 0, 3'd1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
